// File: rtl/snd_rdarb_if.sv
// snd_rdarb_if: requester-side and VRAM-side AXI read signals of snd_rdarb.
// master = arbiter view (drives the VRAM AR/RREADY side); slave = requesters + VRAM model view.
interface snd_rdarb_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       M0_ARADDR;
    logic [7:0]        M0_ARLEN;
    logic              M0_ARVALID;
    logic              M0_ARREADY;
    logic [DATA_W-1:0] M0_RDATA;
    logic              M0_RLAST;
    logic              M0_RVALID;
    logic              M0_RREADY;

    logic [31:0]       M1_ARADDR;
    logic [7:0]        M1_ARLEN;
    logic              M1_ARVALID;
    logic              M1_ARREADY;
    logic [DATA_W-1:0] M1_RDATA;
    logic              M1_RLAST;
    logic              M1_RVALID;
    logic              M1_RREADY;

    logic [31:0]       S_ARADDR;
    logic [7:0]        S_ARLEN;
    logic              S_ARVALID;
    logic              S_ARREADY;
    logic [DATA_W-1:0] S_RDATA;
    logic              S_RLAST;
    logic              S_RVALID;
    logic              S_RREADY;

    modport master (
        input  M0_ARADDR, M0_ARLEN, M0_ARVALID, M0_RREADY,
               M1_ARADDR, M1_ARLEN, M1_ARVALID, M1_RREADY,
               S_ARREADY, S_RDATA, S_RLAST, S_RVALID,
        output M0_ARREADY, M0_RDATA, M0_RLAST, M0_RVALID,
               M1_ARREADY, M1_RDATA, M1_RLAST, M1_RVALID,
               S_ARADDR, S_ARLEN, S_ARVALID, S_RREADY
    );

    modport slave (
        output M0_ARADDR, M0_ARLEN, M0_ARVALID, M0_RREADY,
               M1_ARADDR, M1_ARLEN, M1_ARVALID, M1_RREADY,
               S_ARREADY, S_RDATA, S_RLAST, S_RVALID,
        input  M0_ARREADY, M0_RDATA, M0_RLAST, M0_RVALID,
               M1_ARREADY, M1_RDATA, M1_RLAST, M1_RVALID,
               S_ARADDR, S_ARLEN, S_ARVALID, S_RREADY
    );
endinterface

// File: rtl/snd_rdarb.sv
// snd_rdarb: two-requester AXI read arbiter, whole bursts granted round-robin, one outstanding read.
// Define SND_RDARB_PRIO_EN for fixed M0 priority with an M1 starvation override.
module snd_rdarb #(
    parameter int DATA_W = 32,
    parameter int BEAT_W = 9
) (
    input  logic        ACLK,
    input  logic        ARST,
    snd_rdarb_if.master bus,
    output logic        BUSY,
    output logic        OWNER,
    output logic        PROTERR
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [DATA_W-1:0] RDATA_ZERO = '0;

    state_t            state;
    logic [31:0]       araddr_q;
    logic [7:0]        arlen_q;
    logic              arvalid_q;
    logic [BEAT_W-1:0] beat_cnt;

    logic any_req;
    logic win1;
    logic grant;
    logic r_open;
    logic s_rready;
    logic beat;

    assign any_req = bus.M0_ARVALID | bus.M1_ARVALID;

`ifdef SND_RDARB_PRIO_EN
    logic [3:0] starve_cnt;

    // M0 wins ties unless M1 has already lost eight arbitrations in a row.
    assign win1 = bus.M1_ARVALID & (~bus.M0_ARVALID | (starve_cnt == 4'd8));

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (win1)
                starve_cnt <= 4'd0;
            else if (bus.M1_ARVALID)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    // On a tie the requester that did not own the last burst wins.
    assign win1 = bus.M1_ARVALID & (~bus.M0_ARVALID | ~OWNER);
`endif

    assign grant    = (state == IDLE) & any_req & ~ARST;
    assign r_open   = (state == DATA) & ~ARST;
    assign s_rready = r_open & (OWNER ? bus.M1_RREADY : bus.M0_RREADY);
    assign beat     = s_rready & bus.S_RVALID;

    assign bus.S_ARADDR  = araddr_q;
    assign bus.S_ARLEN   = arlen_q;
    assign bus.S_ARVALID = arvalid_q;

    always_comb begin
        bus.M0_ARREADY = grant & ~win1;
        bus.M1_ARREADY = grant & win1;
        bus.S_RREADY   = s_rready;
        bus.M0_RVALID  = r_open & ~OWNER & bus.S_RVALID;
        bus.M0_RLAST   = r_open & ~OWNER & bus.S_RLAST;
        bus.M0_RDATA   = (r_open & ~OWNER) ? bus.S_RDATA : RDATA_ZERO;
        bus.M1_RVALID  = r_open & OWNER & bus.S_RVALID;
        bus.M1_RLAST   = r_open & OWNER & bus.S_RLAST;
        bus.M1_RDATA   = (r_open & OWNER) ? bus.S_RDATA : RDATA_ZERO;
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state     <= IDLE;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
            BUSY      <= 1'b0;
            OWNER     <= 1'b1;
            PROTERR   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        araddr_q  <= win1 ? bus.M1_ARADDR : bus.M0_ARADDR;
                        arlen_q   <= win1 ? bus.M1_ARLEN : bus.M0_ARLEN;
                        OWNER     <= win1;
                        beat_cnt  <= '0;
                        arvalid_q <= 1'b1;
                        BUSY      <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.S_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        // RLAST must coincide exactly with the beat numbered ARLEN.
                        if (bus.S_RLAST != (beat_cnt == BEAT_W'(arlen_q)))
                            PROTERR <= 1'b1;
                        if (bus.S_RLAST) begin
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/snd_rdarb.md
Name: snd_rdarb

Overview:
Two-requester AXI read-channel arbiter in the sound IP. It shares the single AXI read port to VRAM between two sound read engines, for example two snd_vramctrl-style channels or a sample reader and a descriptor reader. It grants whole bursts round-robin, with one outstanding transaction. The AR request is registered on grant, and R beats are routed to the owner until RLAST.

Parameters:
DATA_W, 32, R data width in bits
BEAT_W, 9, beat counter width; must hold ARLEN+1 = 256

Ports:
ACLK  in  1  clock
ARST  in  1  reset
M0_ARADDR  in  32  requester 0 read address
M0_ARLEN  in  8  requester 0 burst length minus 1
M0_ARVALID  in  1  requester 0 address valid
M0_ARREADY  out  1  requester 0 address accepted
M0_RDATA  out  DATA_W  requester 0 read data
M0_RLAST  out  1  requester 0 last beat
M0_RVALID  out  1  requester 0 data valid
M0_RREADY  in  1  requester 0 data ready
M1_*  same set as M0_*, for requester 1
S_ARADDR  out  32  to VRAM port
S_ARLEN  out  8  to VRAM port
S_ARVALID  out  1  to VRAM port
S_ARREADY  in  1  from VRAM port
S_RDATA  in  DATA_W  from VRAM port
S_RLAST  in  1  from VRAM port
S_RVALID  in  1  from VRAM port
S_RREADY  out  1  to VRAM port
BUSY  out  1  high whenever state is not IDLE
OWNER  out  1  current or last granted requester
PROTERR  out  1  sticky burst-length mismatch flag

Behaviour:
- Reset: ARST is synchronous and active-high; clock is ACLK. On reset:
  - state = IDLE; S_ARVALID = 0; S_ARADDR = 0; S_ARLEN = 0.
  - All M*_ARREADY, M*_RVALID, M*_RLAST = 0; M*_RDATA = 0.
  - S_RREADY = 0; BUSY = 0; OWNER = 1, so M0 wins the first tie; PROTERR = 0; beat counter = 0.
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - Winner: if only one Mx_ARVALID is high, that requester wins. If both are high, the requester != OWNER wins.
  - Mx_ARREADY = 1 for the winner only, combinationally, in the same cycle; that completes the requester handshake.
  - Latch winner's ARADDR/ARLEN into S_ARADDR/S_ARLEN; OWNER <= winner; clear beat counter; go to ADDR.
  - No ARVALID: stay in IDLE.
- ADDR:
  - S_ARVALID = 1 from register; S_ARADDR/S_ARLEN held stable.
  - On S_ARVALID & S_ARREADY go to DATA.
  - Both Mx_ARREADY = 0.
- DATA:
  - Owner path: M[OWNER]_RVALID = S_RVALID, M[OWNER]_RDATA = S_RDATA, M[OWNER]_RLAST = S_RLAST, S_RREADY = M[OWNER]_RREADY. All combinational, zero latency.
  - Non-owner: RVALID = 0, RLAST = 0, RDATA = 0.
  - Beat counter increments on each S_RVALID & S_RREADY.
  - On an accepted beat with S_RLAST = 1: go to IDLE.
- Grant latency: Mx_ARVALID high in cycle N with arbiter idle -> Mx_ARREADY in cycle N, S_ARVALID in cycle N+1.
- Minimum gap between bursts: one IDLE cycle after the RLAST beat.
- Fairness: under continuous requests from both masters, grants alternate M0, M1, M0, ... A requester that re-asserts alone is re-granted immediately.
- PROTERR is set on either of:
  - an accepted beat with S_RLAST = 1 while count != S_ARLEN;
  - an accepted beat with S_RLAST = 0 while count == S_ARLEN.
- PROTERR is cleared only by ARST. The burst still terminates on S_RLAST.
- S_RVALID outside DATA is ignored; S_RREADY = 0 there.
- Mx_ARVALID deasserting while not granted is tolerated and has no effect.
- Reset mid-burst returns to IDLE at once. Outstanding beats arriving afterwards are not forwarded, because S_RREADY = 0.

Optional Feature:
Macro SND_RDARB_PRIO_EN.
- Defined: fixed priority; M0 always wins simultaneous requests. A starvation counter (4 bits) forces an M1 grant after M1 has lost 8 consecutive arbitrations, then resets.
- Undefined: pure round-robin as above; no starvation counter is synthesized.

Test Plan:
- Only M0 requests, ARADDR=0x2000_0100, ARLEN=3 -> M0_ARREADY the same cycle; S_ARVALID next cycle with same addr/len; 4 beats reach M0 only; BUSY low one cycle after RLAST.
- M0 and M1 request together after reset -> M0 granted first, M1 granted on the first IDLE after M0's RLAST; OWNER = 0, then 1.
- Both request continuously, 6 bursts of ARLEN=0 -> grant order 0,1,0,1,0,1.
- S_ARREADY held low 3 cycles in ADDR -> S_ARADDR/S_ARLEN stable, S_ARVALID high throughout, no Mx_ARREADY pulses.
- ARLEN=7 with S_RLAST on beat 5 -> PROTERR = 1 next cycle, stays 1; return to IDLE; next burst proceeds normally.
- ARST asserted on beat 2 of a 16-beat burst -> next cycle BUSY = 0, S_RREADY = 0, all outputs at reset values. A new M1 request is then granted normally.
- SND_RDARB_PRIO_EN defined, both requesting continuously -> M0 granted 8 times, then M1 once, repeating.
